// File: rtl/konix_audio_out.sv
// ============================================================================
// Module   : konix_audio_out
// Purpose  : SlipStream DAC capture, PCM conversion, DC blocker, soft-mute ramp
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module konix_audio_out #(
    parameter int DAC_W    = 14,
    parameter int OUT_W    = 16,
    parameter int DC_SHIFT = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    qclk,
    input  logic [DAC_W-1:0]        left_dac,
    input  logic [DAC_W-1:0]        right_dac,
    input  logic                    dc_block_en,
    input  logic                    mute,
    output logic signed [OUT_W-1:0] audio_l,
    output logic signed [OUT_W-1:0] audio_r,
    output logic                    sample_strobe,
    output logic                    clip
);

    localparam int c_EST_W   = OUT_W + DC_SHIFT + 1;
    localparam int c_Y_W     = OUT_W + 1;
    localparam int c_SHL     = OUT_W - DAC_W;
    localparam int c_G_W     = 5;
    localparam int c_G_SHIFT = 4;
    localparam int c_P_W     = OUT_W + c_G_SHIFT;
    localparam logic [c_G_W-1:0]        c_G_MAX = 5'd16;
    localparam logic signed [OUT_W-1:0] c_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

    // Offset-binary to signed: flip the MSB, then scale up to full PCM range.
    function automatic logic signed [OUT_W-1:0] f_conv(input logic [DAC_W-1:0] d);
        logic signed [DAC_W-1:0] v;
        v = {~d[DAC_W-1], d[DAC_W-2:0]};
        return OUT_W'(v) <<< c_SHL;
    endfunction

    function automatic logic signed [OUT_W-1:0] f_sat(input logic signed [c_Y_W-1:0] y);
        if (y[c_Y_W-1] != y[c_Y_W-2])
            return y[c_Y_W-1] ? c_MIN : c_MAX;
        return y[OUT_W-1:0];
    endfunction

    logic                    r_sync1, r_sync2, r_sync3;
    logic                    r_c_valid, r_d_valid;
    logic [DAC_W-1:0]        r_cap_l, r_cap_r;
    logic signed [c_EST_W-1:0] r_est_l, r_est_r;
    logic signed [OUT_W-1:0] r_yl, r_yr;
    logic                    r_clip_d;
    logic [c_G_W-1:0]        r_g;

    logic                    w_edge;
    logic signed [OUT_W-1:0] w_xl, w_xr;
    logic signed [c_Y_W-1:0] w_shl, w_shr;
    logic signed [c_Y_W-1:0] w_yl, w_yr;
    logic                    w_ovl, w_ovr;
    logic signed [c_P_W-1:0] w_pl, w_pr;
    logic                    w_frac_unused;

    assign w_edge = r_sync2 & ~r_sync3;

    assign w_xl  = f_conv(r_cap_l);
    assign w_xr  = f_conv(r_cap_r);
    assign w_shl = c_Y_W'(r_est_l >>> DC_SHIFT);
    assign w_shr = c_Y_W'(r_est_r >>> DC_SHIFT);
    assign w_yl  = c_Y_W'(w_xl) - w_shl;
    assign w_yr  = c_Y_W'(w_xr) - w_shr;
    assign w_ovl = w_yl[c_Y_W-1] ^ w_yl[c_Y_W-2];
    assign w_ovr = w_yr[c_Y_W-1] ^ w_yr[c_Y_W-2];

    // y*g spans exactly OUT_W+4 bits for g<=16; the top OUT_W bits are (y*g)>>>4.
    assign w_pl = c_P_W'(r_yl) * c_P_W'($signed({1'b0, r_g}));
    assign w_pr = c_P_W'(r_yr) * c_P_W'($signed({1'b0, r_g}));
    assign w_frac_unused = ^{w_pl[c_G_SHIFT-1:0], w_pr[c_G_SHIFT-1:0]};

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_c_valid     <= 1'b0;
            r_d_valid     <= 1'b0;
            r_cap_l       <= '0;
            r_cap_r       <= '0;
            r_est_l       <= '0;
            r_est_r       <= '0;
            r_yl          <= '0;
            r_yr          <= '0;
            r_clip_d      <= 1'b0;
            r_g           <= '0;
            audio_l       <= '0;
            audio_r       <= '0;
            sample_strobe <= 1'b0;
            clip          <= 1'b0;
        end else begin
            r_sync1 <= qclk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            r_c_valid <= w_edge;
            if (w_edge) begin
                r_cap_l <= left_dac;
                r_cap_r <= right_dac;
            end

            r_d_valid <= r_c_valid;
            if (r_c_valid) begin
                if (dc_block_en) begin
                    // Estimator integrates the unsaturated difference.
                    r_est_l  <= r_est_l + c_EST_W'(w_yl);
                    r_est_r  <= r_est_r + c_EST_W'(w_yr);
                    r_yl     <= f_sat(w_yl);
                    r_yr     <= f_sat(w_yr);
                    r_clip_d <= w_ovl | w_ovr;
                end else begin
                    r_est_l  <= '0;
                    r_est_r  <= '0;
                    r_yl     <= w_xl;
                    r_yr     <= w_xr;
                    r_clip_d <= 1'b0;
                end
            end

            sample_strobe <= r_d_valid;
            if (r_d_valid) begin
                audio_l <= w_pl[c_P_W-1 -: OUT_W];
                audio_r <= w_pr[c_P_W-1 -: OUT_W];
                clip    <= r_clip_d;
                if (mute && r_g != '0)
                    r_g <= r_g - 1'b1;
                else if (!mute && r_g < c_G_MAX)
                    r_g <= r_g + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_konix_audio_out.sv
// ============================================================================
// Module   : tb_konix_audio_out
// Purpose  : Self-checking bench for konix_audio_out against an arithmetic model
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_konix_audio_out;

    logic               clk_sys = 1'b0;
    logic               reset_n = 1'b0;
    logic               qclk = 1'b0;
    logic [13:0]        left_dac = '0;
    logic [13:0]        right_dac = '0;
    logic               dc_block_en = 1'b0;
    logic               mute = 1'b0;
    logic signed [15:0] audio_l, audio_r;
    logic               sample_strobe, clip;

    int n_pass  = 0;
    int n_total = 0;

    longint m_est_l, m_est_r;
    int     m_g;

    konix_audio_out #(.DAC_W(14), .OUT_W(16), .DC_SHIFT(8)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .qclk(qclk),
        .left_dac(left_dac), .right_dac(right_dac),
        .dc_block_en(dc_block_en), .mute(mute),
        .audio_l(audio_l), .audio_r(audio_r),
        .sample_strobe(sample_strobe), .clip(clip)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic longint wrapw(input longint v, input int w);
        longint m, r;
        m = longint'(1) << w;
        r = ((v % m) + m) % m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    task automatic model_reset();
        m_est_l = 0;
        m_est_r = 0;
        m_g     = 0;
    endtask

    task automatic model_chan(input logic [13:0] d, input bit en, inout longint est,
                              output longint y, output bit sat);
        longint x;
        x   = (longint'(d) - 8192) * 4;
        sat = 0;
        if (en) begin
            y   = wrapw(x - (est >>> 8), 17);
            est = wrapw(est + y, 25);
            if (y > 32767)       begin y = 32767;  sat = 1; end
            else if (y < -32768) begin y = -32768; sat = 1; end
        end else begin
            y   = x;
            est = 0;
        end
    endtask

    task automatic model_step(input logic [13:0] l, input logic [13:0] r, input bit en,
                              input bit mt, output longint el, output longint er,
                              output bit ec);
        longint yl, yr;
        bit sl, sr;
        model_chan(l, en, m_est_l, yl, sl);
        model_chan(r, en, m_est_r, yr, sr);
        el = (yl * m_g) >>> 4;
        er = (yr * m_g) >>> 4;
        ec = sl | sr;
        if (mt && m_g > 0)        m_g = m_g - 1;
        else if (!mt && m_g < 16) m_g = m_g + 1;
    endtask

    // One qclk pulse; reports first strobe edge index (0 = first edge seeing qclk high).
    task automatic drive_sample(input logic [13:0] l, input logic [13:0] r,
                                output longint ol, output longint orr, output bit oc,
                                output int lat, output int nstb);
        @(negedge clk_sys);
        left_dac = l; right_dac = r; qclk = 1'b1;
        lat = -1; nstb = 0; ol = 0; orr = 0; oc = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk_sys); #1;
            if (n == 2) qclk = 1'b0;
            if (sample_strobe) begin
                nstb++;
                if (lat < 0) begin
                    lat = n; ol = longint'(audio_l); orr = longint'(audio_r); oc = clip;
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        reset_n = 1'b0; qclk = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_total++;
        if (audio_l !== 16'sd0 || audio_r !== 16'sd0 || sample_strobe !== 1'b0 || clip !== 1'b0)
            $display("FAIL reset_outputs got l=%0d r=%0d stb=%b clip=%b required 0/0/0/0",
                     audio_l, audio_r, sample_strobe, clip);
        else n_pass++;
    endtask

    task automatic test_startup_ramp();
        longint ol, orr, el, er, ex; bit oc, ec; int lat, nstb;
        mute = 1'b0; dc_block_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive_sample(14'h3FFF, 14'h3FFF, ol, orr, oc, lat, nstb);
            model_step(14'h3FFF, 14'h3FFF, 1'b0, 1'b0, el, er, ec);
            ex = (longint'(32764) * ((k < 16) ? k : 16)) >>> 4;
            n_total++;
            if (lat != 4 || nstb != 1)
                $display("FAIL ramp_timing k=%0d got lat=%0d strobes=%0d required 4/1", k, lat, nstb);
            else n_pass++;
            n_total++;
            if (ol != ex || orr != ex || oc != 1'b0)
                $display("FAIL ramp_value k=%0d got l=%0d r=%0d clip=%b required %0d clip=0",
                         k, ol, orr, oc, ex);
            else n_pass++;
        end
    endtask

    task automatic test_endpoints();
        logic [13:0] din [3];
        longint      req [3];
        longint ol, orr, el, er; bit oc, ec; int lat, nstb;
        din[0] = 14'h2000; req[0] = 0;
        din[1] = 14'h0000; req[1] = -32768;
        din[2] = 14'h3FFF; req[2] = 32764;
        dc_block_en = 1'b0; mute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_sample(din[i], din[2 - i], ol, orr, oc, lat, nstb);
            model_step(din[i], din[2 - i], 1'b0, 1'b0, el, er, ec);
            n_total++;
            if (lat != 4 || ol != req[i] || orr != req[2 - i] || oc != 1'b0)
                $display("FAIL endpoint d=%h got l=%0d r=%0d clip=%b lat=%0d required l=%0d r=%0d clip=0",
                         din[i], ol, orr, oc, lat, req[i], req[2 - i]);
            else n_pass++;
        end
    endtask

    task automatic test_dc_blocker();
        longint ol, orr, el, er, prev; bit oc, ec; int lat, nstb, bad_model, bad_mono;
        dc_block_en = 1'b1; mute = 1'b0;
        bad_model = 0; bad_mono = 0; prev = 40000; ol = 0;
        for (int i = 0; i < 2048; i++) begin
            drive_sample(14'h3FFF, 14'h3FFF, ol, orr, oc, lat, nstb);
            model_step(14'h3FFF, 14'h3FFF, 1'b1, 1'b0, el, er, ec);
            if (i == 0) begin
                n_total++;
                if (ol != 32764) $display("FAIL dc_first got %0d required 32764", ol);
                else n_pass++;
            end
            if (i == 1) begin
                n_total++;
                if (ol != 32637) $display("FAIL dc_second got %0d required 32637", ol);
                else n_pass++;
            end
            if (lat != 4 || ol != el || orr != er || oc != ec) bad_model++;
            if (ol > prev) bad_mono++;
            prev = ol;
        end
        n_total++;
        if (bad_model != 0) $display("FAIL dc_model got %0d differing samples required 0", bad_model);
        else n_pass++;
        n_total++;
        if (bad_mono != 0) $display("FAIL dc_monotonic got %0d rising steps required 0", bad_mono);
        else n_pass++;
        n_total++;
        if (ol >= 256 || ol <= -256) $display("FAIL dc_settled got %0d required |y|<256", ol);
        else n_pass++;
    endtask

    task automatic test_clip();
        longint ol, orr, el, er; bit oc, ec, seen_clear; int lat, nstb, bad;
        dc_block_en = 1'b1; mute = 1'b0; bad = 0;
        for (int i = 0; i < 1500; i++) begin
            drive_sample(14'h0000, 14'h0000, ol, orr, oc, lat, nstb);
            model_step(14'h0000, 14'h0000, 1'b1, 1'b0, el, er, ec);
            if (lat != 4 || ol != el || orr != er || oc != ec) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL clip_settle got %0d differing samples required 0", bad);
        else n_pass++;
        drive_sample(14'h3FFF, 14'h3FFF, ol, orr, oc, lat, nstb);
        model_step(14'h3FFF, 14'h3FFF, 1'b1, 1'b0, el, er, ec);
        n_total++;
        if (ol != 32767 || orr != 32767 || oc != 1'b1)
            $display("FAIL clip_step got l=%0d r=%0d clip=%b required 32767/32767/1", ol, orr, oc);
        else n_pass++;
        seen_clear = 0; bad = 0;
        for (int i = 0; i < 600 && !seen_clear; i++) begin
            drive_sample(14'h3FFF, 14'h3FFF, ol, orr, oc, lat, nstb);
            model_step(14'h3FFF, 14'h3FFF, 1'b1, 1'b0, el, er, ec);
            if (lat != 4 || ol != el || orr != er || oc != ec) bad++;
            if (!ec) begin
                seen_clear = 1;
                n_total++;
                if (oc != 1'b0 || ol >= 32767)
                    $display("FAIL clip_release got clip=%b l=%0d required clip=0 l<32767", oc, ol);
                else n_pass++;
            end
        end
        n_total++;
        if (bad != 0 || !seen_clear)
            $display("FAIL clip_recover got %0d differing samples cleared=%b required 0/1", bad, seen_clear);
        else n_pass++;
    endtask

    task automatic test_soft_mute();
        int gl [10];
        longint ol, orr, el, er, ex; bit oc, ec; int lat, nstb;
        gl = '{16, 15, 14, 13, 12, 11, 12, 13, 14, 15};
        dc_block_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mute = (i < 5);
            drive_sample(14'h3FFF, 14'h3FFF, ol, orr, oc, lat, nstb);
            model_step(14'h3FFF, 14'h3FFF, 1'b0, mute, el, er, ec);
            ex = (longint'(32764) * gl[i]) >>> 4;
            n_total++;
            if (lat != 4 || ol != ex || orr != ex)
                $display("FAIL soft_mute i=%0d got l=%0d r=%0d required %0d (g=%0d)", i, ol, orr, ex, gl[i]);
            else n_pass++;
        end
        mute = 1'b0;
    endtask

    task automatic test_random();
        longint ol, orr, el, er; bit oc, ec; int lat, nstb;
        logic [13:0] l, r;
        for (int i = 0; i < 200; i++) begin
            l = 14'($urandom_range(0, 16383));
            r = 14'($urandom_range(0, 16383));
            dc_block_en = ($urandom_range(0, 3) != 0);
            mute = ($urandom_range(0, 3) == 0);
            drive_sample(l, r, ol, orr, oc, lat, nstb);
            model_step(l, r, dc_block_en, mute, el, er, ec);
            n_total++;
            if (lat != 4 || nstb != 1 || ol != el || orr != er || oc != ec)
                $display("FAIL random i=%0d got l=%0d r=%0d clip=%b lat=%0d required l=%0d r=%0d clip=%b lat=4",
                         i, ol, orr, oc, lat, el, er, ec);
            else n_pass++;
        end
        mute = 1'b0;
    endtask

    task automatic test_long_high();
        longint ol, orr, el, er; bit oc, ec; int nstb;
        dc_block_en = 1'b0; mute = 1'b0; nstb = 0; ol = 0; orr = 0;
        @(negedge clk_sys);
        left_dac = 14'h1234; right_dac = 14'h2ABC; qclk = 1'b1;
        for (int n = 0; n < 56; n++) begin
            @(posedge clk_sys); #1;
            if (n == 49) qclk = 1'b0;
            if (sample_strobe) begin
                nstb++; ol = longint'(audio_l); orr = longint'(audio_r);
            end
        end
        model_step(14'h1234, 14'h2ABC, 1'b0, 1'b0, el, er, ec);
        n_total++;
        if (nstb != 1 || ol != el || orr != er)
            $display("FAIL long_high got strobes=%0d l=%0d r=%0d required 1/%0d/%0d", nstb, ol, orr, el, er);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nstb, nz;
        nstb = 0; nz = 0;
        @(negedge clk_sys);
        left_dac = 14'h3FFF; right_dac = 14'h3FFF; qclk = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b0; qclk = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk_sys); #1;
            if (sample_strobe) nstb++;
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
        for (int n = 0; n < 8; n++) begin
            @(posedge clk_sys); #1;
            if (sample_strobe) nstb++;
            if (audio_l !== 16'sd0 || audio_r !== 16'sd0 || clip !== 1'b0) nz++;
        end
        n_total++;
        if (nstb != 0) $display("FAIL reset_mid_strobe got %0d strobes required 0", nstb);
        else n_pass++;
        n_total++;
        if (nz != 0) $display("FAIL reset_mid_outputs got %0d nonzero cycles required 0", nz);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup_ramp();
        test_endpoints();
        test_dc_blocker();
        test_clip();
        test_soft_mute();
        test_random();
        test_long_high();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/konix_audio_out.md
# konix_audio_out

Audio output stage downstream of the SlipStream sound DACs. It samples the 14-bit left/right DAC words on each rising edge of the SlipStream DAC strobe (DQCLK). It converts them to signed 16-bit PCM, applies an optional DC-blocking high-pass filter and a pop-free soft-mute gain ramp, and drives the core's AudioL/AudioR outputs with a one-cycle sample strobe.

## Interface
Parameters:
- DAC_W, 14, DAC word width from SlipStream (offset binary)
- OUT_W, 16, PCM output width (signed two's complement)
- DC_SHIFT, 8, DC-estimator time constant as a right-shift amount

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset_n  in  1  synchronous, active-low reset
- qclk  in  1  DAC sample strobe (DQCLK), asynchronous to clk_sys in intent; sampled on its rising edge
- left_dac  in  DAC_W  left DAC word, stable around qclk rise
- right_dac  in  DAC_W  right DAC word, stable around qclk rise
- dc_block_en  in  1  1 = DC blocker active, 0 = bypass
- mute  in  1  1 = ramp gain to 0, 0 = ramp gain to unity
- audio_l  out  OUT_W  left PCM sample
- audio_r  out  OUT_W  right PCM sample
- sample_strobe  out  1  one-cycle pulse when audio_l/audio_r update
- clip  out  1  set with a sample if either channel saturated in the DC stage; held until the next sample

## Operation
- **qclk synchroniser**
  - 3-flop chain: sync1, sync2, sync3.
  - edge = sync2 & ~sync3.
- **Stage C (capture)**
  - On edge, register left_dac and right_dac.
- **Stage D (convert + DC)**
  - Conversion: x = (d − 2^(DAC_W−1)) << (OUT_W−DAC_W), signed OUT_W. Equivalent to inverting the MSB and left-shifting by 2.
    - 14'h2000 → 0; 14'h3FFF → 32764; 14'h0000 → −32768.
  - Per-channel estimator est: signed, OUT_W+DC_SHIFT+1 bits.
  - With dc_block_en=1:
    - y = x − (est >>> DC_SHIFT), computed in OUT_W+1 bits.
    - est ← est + y, using the unsaturated y.
    - y is saturated to [−32768, 32767]; saturation of either channel sets the clip candidate.
  - With dc_block_en=0: y = x, est ← 0, no clip.
- **Stage G (gain)**
  - 5-bit gain g ∈ 0..16; out = (y × g) >>> 4. g=16 is exact unity and g=0 gives 0.
  - Each sample uses the current g. After that sample, g steps by one: if mute=1 and g>0, g−1; if mute=0 and g<16, g+1; otherwise unchanged.
  - g is sampled per output sample. A mute toggle reverses the ramp direction from the current g, with no jump.
- **Outputs**
  - audio_l, audio_r and clip register together in the cycle sample_strobe is high, and hold until the next sample.
- Pipeline accepts one sample per edge. The synchroniser limits edges to at most one every 2 cycles, so no backpressure or overrun case exists.
- No state other than est, g, the pipeline registers and the synchroniser.

## Timing
- **Reset** (reset_n=0 at a clk_sys edge):
  - Outputs: audio_l=0, audio_r=0, sample_strobe=0, clip=0.
  - Internal: sync1..3=0, est=0, g=0, all pipeline valid bits=0.
  - Startup therefore ramps up from silence.
- **Reset mid-pipeline:** in-flight samples are discarded and no strobe is produced for them.
- **Latency:** cycle 0 is the first clk_sys edge capturing qclk=1 into sync1.
  - Capture at edge 2, stage D at edge 3.
  - audio_*, clip and sample_strobe=1 at edge 4; sample_strobe returns to 0 at edge 5.
  - Total: 4 clk_sys edges from qclk-high sampling to output.
- **qclk level:** a qclk high held for any number of cycles yields exactly one sample. A qclk low pulse shorter than one clk_sys period may be missed; this is accepted.
- **Control inputs:** dc_block_en is sampled in stage D. mute is sampled at the stage-G update.
- **Coincident events:** est update and gain step for a sample occur in the same cycle as that sample's stage, so no coincident-event ordering issue exists.

## Test plan
- **Reset / startup ramp:** reset, mute=0, dc_block_en=0, left=right=14'h3FFF, 20 qclk pulses.
  - Outputs 0, 2047, 4095, … (32764×k>>>4 for k=0..16), then steady 32764.
  - 20 strobes, each 4 cycles after qclk sampled high.
- **Conversion endpoints:** after the ramp completes with DC bypassed, apply 14'h2000, 14'h0000 and 14'h3FFF.
  - audio_l = 0, −32768, 32764 respectively; clip=0.
- **DC blocker:** dc_block_en=1, g=16, constant 14'h3FFF.
  - First output 32764 with est=32764.
  - Second output 32764−127=32637.
  - Output decays monotonically toward |y|<256 within 2048 samples.
- **Clip:** dc_block_en=1, settle on 14'h0000 (est≈−32768·256), then step to 14'h3FFF.
  - Output saturates at 32767 with clip=1 on that sample.
  - clip=0 once y re-enters range.
- **Soft mute mid-ramp:** from g=16 assert mute for 5 samples, then deassert.
  - Gains 16,15,14,13,12, then 11,12,13…; no discontinuity.
- **Long-high qclk and reset mid-operation:**
  - qclk held high 50 cycles → exactly one strobe.
  - reset_n low at edge 3 after a qclk rise → no strobe, outputs 0.
